uart_port_ctrl: RTL and testbench

Handshake engine for the on-board UART chip, which shares the RAM1 data bus. Sits between the CPU's memory controller (UART-mapped loads/stores) and the board pins data_ready/rdn/tbre/tsre/wrn.
- Drains received bytes into a receive FIFO.
- Transmits single bytes on request.
- Owns the shared data bus while a transfer is in progress.

---
 rtl/uart_port_ctrl_if.sv | 39 +++
 rtl/uart_port_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_port_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_port_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_port_ctrl_if
//   CPU-side handshake bundle of the UART port controller: the receive-FIFO
//   read side and the single-byte transmit request.
//
//   Signals (direction seen from the controller, i.e. the slave modport):
//     rx_pop      in   consume head of receive FIFO
//     rx_data     out  head of receive FIFO (valid when rx_valid)
//     rx_valid    out  receive FIFO non-empty
//     rx_count    out  receive FIFO occupancy (DEPTH_LOG2+1 bits)
//     rx_overflow out  sticky, a received byte was dropped (FIFO full)
//     tx_req      in   start transmit of tx_data (taken while tx_ready)
//     tx_data     in   byte to transmit
//     tx_ready    out  transmitter idle, tx_req will be accepted
// ---------------------------------------------------------------------------
interface uart_port_ctrl_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  rx_pop;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [DEPTH_LOG2:0]   rx_count;
  logic                  rx_overflow;
  logic                  tx_req;
  logic [7:0]            tx_data;
  logic                  tx_ready;

  // CPU / memory-controller side
  modport master (
    output rx_pop, tx_req, tx_data,
    input  rx_data, rx_valid, rx_count, rx_overflow, tx_ready
  );

  // UART port controller side
  modport slave (
    input  rx_pop, tx_req, tx_data,
    output rx_data, rx_valid, rx_count, rx_overflow, tx_ready
  );
endinterface

// File: rtl/uart_port_ctrl.sv
// ---------------------------------------------------------------------------
// uart_port_ctrl
//   Handshake engine for the on-board UART that shares the RAM1 data bus.
//   Received bytes are drained into a small circular FIFO; single bytes are
//   transmitted on request. While a transfer is in progress the controller
//   owns the shared bus and asks for RAM1 to be disabled.
//
//   Optional build macro: UART_DEBUG_CNT_EN
//     defined   -> dbg_rx_total / dbg_tx_total are 16-bit wrapping counters
//                  of pushed bytes and completed writes
//     undefined -> both debug outputs are tied to zero
//
//   Ports:
//     clk          in   system clock, rising edge
//     rst          in   asynchronous reset, active-low
//     data_ready   in   UART byte-available pin (asynchronous)
//     tbre         in   UART transmit-buffer-empty pin (asynchronous)
//     tsre         in   UART transmit-shift-register-empty pin (asynchronous)
//     rdn          out  UART read strobe, active-low
//     wrn          out  UART write strobe, active-low
//     bus_din      in   sampled shared data bus
//     bus_dout     out  value driven onto the shared bus
//     bus_oe       out  1 = drive bus_dout onto the bus
//     ram_inhibit  out  1 = RAM1 must be disabled (bus owned by UART)
//     cpu          if   CPU-side FIFO / transmit handshake (slave modport)
//     dbg_rx_total out  debug count of received bytes
//     dbg_tx_total out  debug count of transmitted bytes
// ---------------------------------------------------------------------------
module uart_port_ctrl #(
  parameter int DEPTH_LOG2 = 3,
  parameter int RD_CYCLES  = 2,
  parameter int WR_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_ready,
  input  logic             tbre,
  input  logic             tsre,
  output logic             rdn,
  output logic             wrn,
  input  logic [15:0]      bus_din,
  output logic [15:0]      bus_dout,
  output logic             bus_oe,
  output logic             ram_inhibit,
  uart_port_ctrl_if.slave  cpu,
  output logic [15:0]      dbg_rx_total,
  output logic [15:0]      dbg_tx_total
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [DEPTH_LOG2:0] DEPTH_C   = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [CNT_W-1:0]    RD_LAST_C = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    WR_LAST_C = CNT_W'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    RD_RECOVER,
    WR_SETUP,
    WR_STROBE,
    WR_WAIT
  } state_e;

  // -------------------------------------------------------------------------
  // Input synchronisers for the asynchronous UART status pins
  // -------------------------------------------------------------------------
  logic [1:0] dr_sync, tbre_sync, tsre_sync;
  logic       dr_s, tbre_s, tsre_s;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, as real hardware does.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dr_sync   <= '0;
      tbre_sync <= '0;
      tsre_sync <= '0;
    end else begin
      dr_sync   <= {dr_sync[0],   data_ready};
      tbre_sync <= {tbre_sync[0], tbre};
      tsre_sync <= {tsre_sync[0], tsre};
    end
  end

  assign dr_s   = dr_sync[1];
  assign tbre_s = tbre_sync[1];
  assign tsre_s = tsre_sync[1];

  // -------------------------------------------------------------------------
  // Transmit latch
  // -------------------------------------------------------------------------
  logic       tx_pend;
  logic [7:0] tx_buf;
  logic       wr_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_pend <= 1'b0;
      tx_buf  <= '0;
    end else if (cpu.tx_req && !tx_pend) begin
      tx_pend <= 1'b1;
      tx_buf  <= cpu.tx_data;
    end else if (wr_done) begin
      tx_pend <= 1'b0;
    end
  end

  assign cpu.tx_ready = !tx_pend;

  // -------------------------------------------------------------------------
  // Handshake FSM
  // -------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobe-width counter is zero on entry to each strobe state because it
  // defaults to zero in every other state.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    rd_capture  = 1'b0;
    wr_done     = 1'b0;
    rdn         = 1'b1;
    wrn         = 1'b1;
    bus_oe      = 1'b0;
    bus_dout    = '0;
    ram_inhibit = 1'b1;

    unique case (state_q)
      IDLE: begin
        ram_inhibit = 1'b0;
        // Receive wins over transmit so the UART holding register is
        // emptied before it can be overrun.
        if (dr_s) begin
          state_d = RD_STROBE;
        end else if (tx_pend && tbre_s && tsre_s) begin
          state_d = WR_SETUP;
        end
      end
      RD_STROBE: begin
        rdn = 1'b0;
        if (cnt_q == RD_LAST_C) begin
          rd_capture = 1'b1;
          state_d    = RD_RECOVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_RECOVER: begin
        // Wait for the UART to drop data_ready, otherwise the same byte
        // would be read a second time.
        if (!dr_s) begin
          state_d = IDLE;
        end
      end
      WR_SETUP: begin
        // Data is on the bus one cycle before wrn falls.
        bus_oe   = 1'b1;
        bus_dout = {8'h00, tx_buf};
        state_d  = WR_STROBE;
      end
      WR_STROBE: begin
        wrn      = 1'b0;
        bus_oe   = 1'b1;
        bus_dout = {8'h00, tx_buf};
        if (cnt_q == WR_LAST_C) begin
          state_d = WR_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_WAIT: begin
        // Bus is released while the UART shifts the byte out.
        ram_inhibit = 1'b0;
        if (tbre_s && tsre_s) begin
          wr_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Receive FIFO
  // -------------------------------------------------------------------------
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  full, empty, push, pop;
  logic                  unused_bus_hi;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign pop   = cpu.rx_pop && !empty;
  // A pop in the capture cycle frees a slot, so a full FIFO still accepts.
  assign push  = rd_capture && (!full || pop);

  // Upper bus byte is not part of the UART data path.
  assign unused_bus_hi = ^bus_din[15:8];

  // NOTE: the storage array has no reset; only pointers and count do, and
  // rx_data is masked while empty so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus_din[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      cpu.rx_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rd_capture && !push) begin
        cpu.rx_overflow <= 1'b1;
      end
    end
  end

  assign cpu.rx_data  = empty ? 8'h00 : mem[rd_ptr];
  assign cpu.rx_valid = !empty;
  assign cpu.rx_count = count;

  // -------------------------------------------------------------------------
  // Debug counters
  // -------------------------------------------------------------------------
`ifdef UART_DEBUG_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_rx_total <= '0;
      dbg_tx_total <= '0;
    end else begin
      if (push)    dbg_rx_total <= dbg_rx_total + 1'b1;
      if (wr_done) dbg_tx_total <= dbg_tx_total + 1'b1;
    end
  end
`else
  assign dbg_rx_total = 16'h0000;
  assign dbg_tx_total = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_port_ctrl
//   Directed bench for uart_port_ctrl (DEPTH_LOG2=3, RD_CYCLES=WR_CYCLES=2).
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_port_ctrl;

  localparam int RD_CYC = 2;
  localparam int WR_CYC = 2;

`ifdef UART_DEBUG_CNT_EN
  localparam int EXP_DBG_RX = 9;
  localparam int EXP_DBG_TX = 1;
`else
  localparam int EXP_DBG_RX = 0;
  localparam int EXP_DBG_TX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_ready, tbre, tsre;
  logic        rdn, wrn, bus_oe, ram_inhibit;
  logic [15:0] bus_din, bus_dout;
  logic [15:0] dbg_rx_total, dbg_tx_total;

  int errors = 0;
  int checks = 0;

  uart_port_ctrl_if #(.DEPTH_LOG2(3)) cpu_if ();

  uart_port_ctrl #(
    .DEPTH_LOG2 (3),
    .RD_CYCLES  (RD_CYC),
    .WR_CYCLES  (WR_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_ready   (data_ready),
    .tbre         (tbre),
    .tsre         (tsre),
    .rdn          (rdn),
    .wrn          (wrn),
    .bus_din      (bus_din),
    .bus_dout     (bus_dout),
    .bus_oe       (bus_oe),
    .ram_inhibit  (ram_inhibit),
    .cpu          (cpu_if),
    .dbg_rx_total (dbg_rx_total),
    .dbg_tx_total (dbg_tx_total)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle_inputs();
    data_ready       = 1'b0;
    tbre             = 1'b1;
    tsre             = 1'b1;
    bus_din          = '0;
    cpu_if.rx_pop    = 1'b0;
    cpu_if.tx_req    = 1'b0;
    cpu_if.tx_data   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Present one byte, drop data_ready once rdn falls, measure the rdn-low
  // width, optionally pop in the capture cycle, and return once back in IDLE.
  task automatic read_byte(input logic [7:0] b, input bit pop_at_capture, output int width);
    int n;
    width      = 0;
    bus_din    = {8'h00, b};
    data_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdn && n < 20);
    if (rdn) begin
      check("rd_start", 32'(rdn), 0);
      data_ready = 1'b0;
      return;
    end
    data_ready = 1'b0;
    width = 1;
    if (pop_at_capture && width == RD_CYC) cpu_if.rx_pop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cpu_if.rx_pop = 1'b0;
      if (rdn) break;
      width++;
      if (pop_at_capture && width == RD_CYC) cpu_if.rx_pop = 1'b1;
    end
    n = 0;
    while (ram_inhibit && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ram_inhibit) check("rd_recover", 32'(ram_inhibit), 0);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check(tag, 32'(cpu_if.rx_data), 32'(exp));
    cpu_if.rx_pop = 1'b1;
    @(negedge clk);
    cpu_if.rx_pop = 1'b0;
  endtask

  task automatic send_req(input logic [7:0] d);
    cpu_if.tx_data = d;
    cpu_if.tx_req  = 1'b1;
    @(negedge clk);
    cpu_if.tx_req  = 1'b0;
  endtask

  initial begin
    int w, n, cnt, rd_at, wr_at, inh_bad, clash;

    // ---------------- reset state ----------------
    set_idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_rdn",      32'(rdn), 1);
    check("rst_wrn",      32'(wrn), 1);
    check("rst_bus_oe",   32'(bus_oe), 0);
    check("rst_bus_dout", 32'(bus_dout), 0);
    check("rst_inhibit",  32'(ram_inhibit), 0);
    check("rst_rx_valid", 32'(cpu_if.rx_valid), 0);
    check("rst_rx_count", 32'(cpu_if.rx_count), 0);
    check("rst_overflow", 32'(cpu_if.rx_overflow), 0);
    check("rst_rx_data",  32'(cpu_if.rx_data), 0);
    check("rst_tx_ready", 32'(cpu_if.tx_ready), 1);
    check("rst_dbg_rx",   32'(dbg_rx_total), 0);
    check("rst_dbg_tx",   32'(dbg_tx_total), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // ---------------- 1: single byte ----------------
    read_byte(8'h41, 1'b0, w);
    check("t1_rdn_width", 32'(w), RD_CYC);
    check("t1_rx_valid",  32'(cpu_if.rx_valid), 1);
    check("t1_rx_data",   32'(cpu_if.rx_data), 'h41);
    check("t1_rx_count",  32'(cpu_if.rx_count), 1);
    check("t1_idle",      32'(ram_inhibit), 0);
    pop_expect("t1_pop", 8'h41);
    check("t1_empty", 32'(cpu_if.rx_valid), 0);

    // ---------------- 2: overflow ----------------
    for (int i = 0; i < 9; i++) read_byte(8'(i), 1'b0, w);
    check("t2_count",    32'(cpu_if.rx_count), 8);
    check("t2_overflow", 32'(cpu_if.rx_overflow), 1);
    check("t2_dbg_rx",   32'(dbg_rx_total), EXP_DBG_RX);
    check("t2_dbg_tx",   32'(dbg_tx_total), 0);
    for (int i = 0; i < 8; i++) pop_expect($sformatf("t2_pop%0d", i), 8'(i));
    check("t2_empty",       32'(cpu_if.rx_valid), 0);
    check("t2_count_after", 32'(cpu_if.rx_count), 0);
    check("t2_ovf_sticky",  32'(cpu_if.rx_overflow), 1);

    // ---------------- 3: push + pop on full FIFO ----------------
    do_reset();
    for (int i = 0; i < 8; i++) read_byte(8'('h10 + i), 1'b0, w);
    check("t3_full_count", 32'(cpu_if.rx_count), 8);
    check("t3_full_ovf",   32'(cpu_if.rx_overflow), 0);
    read_byte(8'h55, 1'b1, w);
    check("t3_count",    32'(cpu_if.rx_count), 8);
    check("t3_overflow", 32'(cpu_if.rx_overflow), 0);
    for (int i = 1; i < 8; i++) pop_expect($sformatf("t3_pop%0d", i), 8'('h10 + i));
    pop_expect("t3_pop_last", 8'h55);
    check("t3_empty", 32'(cpu_if.rx_valid), 0);

    // ---------------- 4: transmit ----------------
    send_req(8'h5A);
    check("t4_busy", 32'(cpu_if.tx_ready), 0);
    n = 0;
    while (!bus_oe && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_oe",         32'(bus_oe), 1);
    check("t4_setup_dout", 32'(bus_dout), 'h005A);
    check("t4_setup_wrn",  32'(wrn), 1);
    check("t4_setup_inh",  32'(ram_inhibit), 1);
    @(negedge clk);
    check("t4_wrn_fall", 32'(wrn), 0);
    tbre = 1'b0;
    w = 0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (wrn) break;
      w++;
      if (!bus_oe || bus_dout !== 16'h005A) cnt++;
      @(negedge clk);
    end
    check("t4_wrn_width", 32'(w), WR_CYC);
    check("t4_hold_bus",  32'(cnt), 0);
    check("t4_wait_oe",   32'(bus_oe), 0);
    check("t4_wait_inh",  32'(ram_inhibit), 0);
    send_req(8'hFF);  // must be ignored: transmitter busy
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_if.tx_ready) cnt++;
    end
    check("t4_ready_held", 32'(cnt), 0);
    tbre = 1'b1;
    n = 0;
    while (!cpu_if.tx_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t4_ready", 32'(cpu_if.tx_ready), 1);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (!wrn) cnt++;
    end
    check("t4_no_extra_wr", 32'(cnt), 0);
    check("t4_dbg_rx", 32'(dbg_rx_total), EXP_DBG_RX);
    check("t4_dbg_tx", 32'(dbg_tx_total), EXP_DBG_TX);

    // ---------------- 5: read and write requested together ----------------
    // data_ready leads tx_req by one cycle to cover its extra synchroniser
    // stage, so both requests are visible in IDLE in the same cycle.
    bus_din    = 16'h0077;
    data_ready = 1'b1;
    @(negedge clk);
    send_req(8'h3C);
    rd_at = -1;
    wr_at = -1;
    inh_bad = 0;
    clash = 0;
    for (int c = 0; c < 60; c++) begin
      if (!rdn) begin
        if (rd_at < 0) rd_at = c;
        data_ready = 1'b0;
        if (!ram_inhibit) inh_bad++;
        if (bus_oe) clash++;
      end
      if (!wrn && wr_at < 0) wr_at = c;
      if (rd_at >= 0 && wr_at >= 0 && cpu_if.tx_ready) break;
      @(negedge clk);
    end
    check("t5_read_first", 32'(rd_at >= 0 && wr_at > rd_at), 1);
    check("t5_inhibit",    32'(inh_bad), 0);
    check("t5_bus_clash",  32'(clash), 0);
    check("t5_tx_ready",   32'(cpu_if.tx_ready), 1);
    pop_expect("t5_rx_data", 8'h77);

    // ---------------- 6: reset in WR_STROBE ----------------
    send_req(8'hA5);
    n = 0;
    while (wrn && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_wrn_fall", 32'(wrn), 0);
    #1 rst = 1'b0;
    #1;
    check("t6_async_wrn", 32'(wrn), 1);
    check("t6_async_oe",  32'(bus_oe), 0);
    check("t6_async_inh", 32'(ram_inhibit), 0);
    set_idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_tx_ready", 32'(cpu_if.tx_ready), 1);
    check("t6_rx_valid", 32'(cpu_if.rx_valid), 0);
    check("t6_rx_count", 32'(cpu_if.rx_count), 0);
    check("t6_dbg_rx",   32'(dbg_rx_total), 0);
    check("t6_dbg_tx",   32'(dbg_tx_total), 0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (!wrn) cnt++;
    end
    check("t6_no_write", 32'(cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
